// File: rtl/si570_i2c_target.sv
// si570_i2c_target
// ----------------------------------------------------------------------------
// I2C target that models the Si570 register subset driven by the Si570
// configuration master:
//   - HS_DIV / N1 / RFREQ shadow registers 7..12
//   - register 135 (RECALL bit0, NewFreq bit6)
//   - register 137 (FreezeDCO bit4)
// The divider configuration that is currently applied is exposed on output
// ports, so a bench can check the master's frequency arithmetic. Any other
// register reads as 0x00, and writes to it are ACKed and dropped.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   scl        I2C clock; only ever pulled low (clock stretching build), else z
//   sda        I2C data; pulled low or left z, never driven high
//   hs_div     applied raw HS_DIV field
//   n1         applied raw N1 field (N1-1 encoding)
//   rfreq      applied raw RFREQ field
//   frozen     FreezeDCO state (reg 137 bit4)
//   new_freq   one-cycle pulse when NewFreq is written
//   bus_active high from any START to the next STOP
//
// Build option
//   SI570_TARGET_CLOCK_STRETCH_EN
//     When defined, the target holds SCL low for StretchCycles clocks after
//     the ninth SCL fall of every byte.
//     When undefined, scl is never pulled low.
// ----------------------------------------------------------------------------
module si570_i2c_target #(
  parameter logic [6:0]  I2CAddress    = 7'h55,
  parameter logic [2:0]  FactoryHsDiv  = 3'd2,
  parameter logic [6:0]  FactoryN1     = 7'd7,
  parameter logic [37:0] FactoryRfreq  = 38'h2BC0000000,
  parameter int          FilterDepth   = 3,
  parameter int          RecallCycles  = 16,
  parameter int          StretchCycles = 32
) (
  input  logic        clk,
  input  logic        reset,
  inout  tri1         scl,
  inout  tri1         sda,
  output logic [2:0]  hs_div,
  output logic [6:0]  n1,
  output logic [37:0] rfreq,
  output logic        frozen,
  output logic        new_freq,
  output logic        bus_active
);

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_ADDR      = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
  localparam logic [3:0] ST_PTR       = 4'd3;
  localparam logic [3:0] ST_PTR_ACK   = 4'd4;
  localparam logic [3:0] ST_WDATA     = 4'd5;
  localparam logic [3:0] ST_WDATA_ACK = 4'd6;
  localparam logic [3:0] ST_RDATA     = 4'd7;
  localparam logic [3:0] ST_RDATA_ACK = 4'd8;
  localparam logic [3:0] ST_IGNORE    = 4'd9;

  localparam int FCW = $clog2(FilterDepth + 1);
  localparam int RCW = $clog2(RecallCycles + 1);

  // input conditioning
  logic           scl_meta_r, scl_sync_r, scl_flt_r, scl_prev_r;
  logic           sda_meta_r, sda_sync_r, sda_flt_r, sda_prev_r;
  logic [FCW-1:0] scl_cnt_r, sda_cnt_r;
  logic           scl_rise_s, scl_fall_s, scl_rise_g, scl_fall_g;
  logic           start_s, stop_s, stretching_s;

  // protocol engine
  logic [3:0]     state_r;
  logic [3:0]     bit_cnt_r;
  logic [6:0]     shift_r;
  logic [6:0]     tx_r;
  logic [7:0]     ptr_r;
  logic           rw_r;
  logic           sda_low_r;
  logic [7:0]     rx_byte_s;
  logic [7:0]     rd_data_s;
  logic           commit_s;

  // register file
  logic [2:0]     hs_div_sh_r;
  logic [6:0]     n1_sh_r;
  logic [37:0]    rfreq_sh_r;
  logic [RCW-1:0] recall_cnt_r;
  logic           recall_req_r, newfreq_req_r, thaw_req_r;

  // Two-flop synchronizers plus a stability filter on both bus lines
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_meta_r <= 1'b1;
      scl_sync_r <= 1'b1;
      sda_meta_r <= 1'b1;
      sda_sync_r <= 1'b1;
      scl_flt_r  <= 1'b1;
      sda_flt_r  <= 1'b1;
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
      scl_cnt_r  <= '0;
      sda_cnt_r  <= '0;
    end else begin
      scl_meta_r <= scl;
      scl_sync_r <= scl_meta_r;
      sda_meta_r <= sda;
      sda_sync_r <= sda_meta_r;
      scl_prev_r <= scl_flt_r;
      sda_prev_r <= sda_flt_r;
      // a new level is accepted only after it has differed for FilterDepth cycles
      if (scl_sync_r == scl_flt_r) begin
        scl_cnt_r <= '0;
      end else if (scl_cnt_r == FCW'(FilterDepth - 1)) begin
        scl_flt_r <= scl_sync_r;
        scl_cnt_r <= '0;
      end else begin
        scl_cnt_r <= scl_cnt_r + 1'b1;
      end
      if (sda_sync_r == sda_flt_r) begin
        sda_cnt_r <= '0;
      end else if (sda_cnt_r == FCW'(FilterDepth - 1)) begin
        sda_flt_r <= sda_sync_r;
        sda_cnt_r <= '0;
      end else begin
        sda_cnt_r <= sda_cnt_r + 1'b1;
      end
    end
  end

  assign scl_rise_s = scl_flt_r & ~scl_prev_r;
  assign scl_fall_s = ~scl_flt_r & scl_prev_r;
  // SCL must be high before and after the SDA edge, so SCL and SDA edges
  // that land in the same cycle are not taken as START or STOP
  assign start_s    = scl_flt_r & scl_prev_r & sda_prev_r & ~sda_flt_r;
  assign stop_s     = scl_flt_r & scl_prev_r & ~sda_prev_r & sda_flt_r;
  // while the target itself holds SCL low, bit shifting ignores SCL edges
  assign scl_rise_g = scl_rise_s & ~stretching_s;
  assign scl_fall_g = scl_fall_s & ~stretching_s;
  assign rx_byte_s  = {shift_r, sda_flt_r};
  assign commit_s   = (state_r == ST_WDATA) && scl_rise_g && (bit_cnt_r == 4'd7)
                      && !start_s && !stop_s;

  assign sda = sda_low_r ? 1'b0 : 1'bz;

`ifdef SI570_TARGET_CLOCK_STRETCH_EN
  localparam int StretchW = $clog2(StretchCycles + 1);
  logic [StretchW-1:0] stretch_cnt_r;
  logic                stretch_start_s;

  assign stretch_start_s = scl_fall_g && !start_s && !stop_s &&
                           ((state_r == ST_ADDR_ACK) || (state_r == ST_PTR_ACK) ||
                            (state_r == ST_WDATA_ACK) || (state_r == ST_RDATA_ACK));

  // Hold SCL low for StretchCycles after the ninth SCL fall of each byte
  always_ff @(posedge clk) begin
    if (reset) begin
      stretch_cnt_r <= '0;
    end else if (stretch_start_s) begin
      stretch_cnt_r <= StretchW'(StretchCycles);
    end else if (stretch_cnt_r != '0) begin
      stretch_cnt_r <= stretch_cnt_r - 1'b1;
    end
  end

  assign stretching_s = (stretch_cnt_r != '0);
  assign scl          = stretching_s ? 1'b0 : 1'bz;
`else
  // this build never stretches; the expression folds to constant 0
  assign stretching_s = (StretchCycles < 0);
  assign scl          = 1'bz;
`endif

  // Read multiplexer: register value at the current pointer
  always_comb begin
    rd_data_s = 8'h00;
    case (ptr_r)
      8'd7:    rd_data_s = {hs_div_sh_r, n1_sh_r[6:2]};
      8'd8:    rd_data_s = {n1_sh_r[1:0], rfreq_sh_r[37:32]};
      8'd9:    rd_data_s = rfreq_sh_r[31:24];
      8'd10:   rd_data_s = rfreq_sh_r[23:16];
      8'd11:   rd_data_s = rfreq_sh_r[15:8];
      8'd12:   rd_data_s = rfreq_sh_r[7:0];
      8'd135:  rd_data_s = {7'b0000000, (recall_cnt_r != '0)};
      8'd137:  rd_data_s = {3'b000, frozen, 4'b0000};
      default: rd_data_s = 8'h00;
    endcase
  end

  // Bus protocol state machine: addressing, pointer, write and read bytes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= 4'd0;
      shift_r    <= 7'd0;
      tx_r       <= 7'd0;
      ptr_r      <= 8'd0;
      rw_r       <= 1'b0;
      sda_low_r  <= 1'b0;
      bus_active <= 1'b0;
    end else if (start_s) begin
      // covers repeated START too: any byte in flight is abandoned
      state_r    <= ST_ADDR;
      bit_cnt_r  <= 4'd0;
      sda_low_r  <= 1'b0;
      bus_active <= 1'b1;
    end else if (stop_s) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= 4'd0;
      sda_low_r  <= 1'b0;
      bus_active <= 1'b0;
    end else begin
      case (state_r)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise_g) begin
            shift_r   <= rx_byte_s[6:0];
            bit_cnt_r <= bit_cnt_r + 4'd1;
            if (bit_cnt_r == 4'd7) begin
              if (state_r == ST_ADDR) begin
                if (rx_byte_s[7:1] == I2CAddress) begin
                  rw_r <= rx_byte_s[0];
                end else begin
                  state_r <= ST_IGNORE;
                end
              end else if (state_r == ST_PTR) begin
                ptr_r <= rx_byte_s;
              end else begin
                // the register file commits this byte in the same cycle
                ptr_r <= ptr_r + 8'd1;
              end
            end
          end else if (scl_fall_g && (bit_cnt_r == 4'd8)) begin
            // ACK is held from the 8th SCL fall to the 9th SCL fall
            sda_low_r <= 1'b1;
            if (state_r == ST_ADDR) begin
              state_r <= ST_ADDR_ACK;
            end else if (state_r == ST_PTR) begin
              state_r <= ST_PTR_ACK;
            end else begin
              state_r <= ST_WDATA_ACK;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall_g) begin
            bit_cnt_r <= 4'd0;
            if (rw_r) begin
              state_r   <= ST_RDATA;
              tx_r      <= rd_data_s[6:0];
              sda_low_r <= ~rd_data_s[7];
            end else begin
              state_r   <= ST_PTR;
              sda_low_r <= 1'b0;
            end
          end
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall_g) begin
            state_r   <= ST_WDATA;
            bit_cnt_r <= 4'd0;
            sda_low_r <= 1'b0;
          end
        end
        ST_RDATA: begin
          if (scl_rise_g) begin
            bit_cnt_r <= bit_cnt_r + 4'd1;
          end else if (scl_fall_g) begin
            if (bit_cnt_r == 4'd8) begin
              // byte finished: release for the master's ACK bit
              state_r   <= ST_RDATA_ACK;
              sda_low_r <= 1'b0;
              ptr_r     <= ptr_r + 8'd1;
            end else begin
              sda_low_r <= ~tx_r[6];
              tx_r      <= {tx_r[5:0], 1'b0};
            end
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise_g) begin
            if (sda_flt_r) begin
              state_r <= ST_IGNORE;
            end
          end else if (scl_fall_g) begin
            state_r   <= ST_RDATA;
            bit_cnt_r <= 4'd0;
            tx_r      <= rd_data_s[6:0];
            sda_low_r <= ~rd_data_s[7];
          end
        end
        ST_IDLE, ST_IGNORE: begin
          sda_low_r <= 1'b0;
        end
        default: begin
          state_r   <= ST_IDLE;
          sda_low_r <= 1'b0;
        end
      endcase
    end
  end

  // Register file: shadow writes, recall, NewFreq and freeze handling
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_div_sh_r   <= FactoryHsDiv;
      n1_sh_r       <= FactoryN1;
      rfreq_sh_r    <= FactoryRfreq;
      hs_div        <= FactoryHsDiv;
      n1            <= FactoryN1;
      rfreq         <= FactoryRfreq;
      frozen        <= 1'b0;
      new_freq      <= 1'b0;
      recall_cnt_r  <= '0;
      recall_req_r  <= 1'b0;
      newfreq_req_r <= 1'b0;
      thaw_req_r    <= 1'b0;
    end else begin
      recall_req_r  <= 1'b0;
      newfreq_req_r <= 1'b0;
      thaw_req_r    <= 1'b0;
      new_freq      <= newfreq_req_r;
      if (recall_cnt_r != '0) begin
        recall_cnt_r <= recall_cnt_r - 1'b1;
      end
      // effects of a reg 135/137 write land one cycle after the commit;
      // RECALL goes first, so a combined RECALL+NewFreq applies factory values
      if (recall_req_r) begin
        hs_div_sh_r <= FactoryHsDiv;
        n1_sh_r     <= FactoryN1;
        rfreq_sh_r  <= FactoryRfreq;
      end
      if ((newfreq_req_r && !frozen) || thaw_req_r) begin
        hs_div <= recall_req_r ? FactoryHsDiv : hs_div_sh_r;
        n1     <= recall_req_r ? FactoryN1    : n1_sh_r;
        rfreq  <= recall_req_r ? FactoryRfreq : rfreq_sh_r;
      end
      if (commit_s) begin
        case (ptr_r)
          8'd7:  {hs_div_sh_r, n1_sh_r[6:2]}        <= rx_byte_s;
          8'd8:  {n1_sh_r[1:0], rfreq_sh_r[37:32]}  <= rx_byte_s;
          8'd9:  rfreq_sh_r[31:24] <= rx_byte_s;
          8'd10: rfreq_sh_r[23:16] <= rx_byte_s;
          8'd11: rfreq_sh_r[15:8]  <= rx_byte_s;
          8'd12: rfreq_sh_r[7:0]   <= rx_byte_s;
          8'd135: begin
            recall_req_r  <= rx_byte_s[0];
            newfreq_req_r <= rx_byte_s[6];
            if (rx_byte_s[0]) begin
              recall_cnt_r <= RCW'(RecallCycles);
            end
          end
          8'd137: begin
            frozen     <= rx_byte_s[4];
            thaw_req_r <= frozen & ~rx_byte_s[4];
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_si570_i2c_target.sv
// tb_si570_i2c_target
// ----------------------------------------------------------------------------
// Self-checking bench for si570_i2c_target. A bit-banged I2C master drives
// the open-drain bus. Each transaction pushes its expected ACK or read byte
// into a queue. The matching entry is popped and compared once the target
// has produced that bit or byte. Applied-output values are checked directly
// against constants.
// ----------------------------------------------------------------------------
module tb_si570_i2c_target;

  localparam int Q          = 12;    // clocks per quarter SCL period
  localparam int RECALL_CYC = 2500;

  logic        clk = 1'b0;
  logic        reset;
  tri1         scl_bus;
  tri1         sda_bus;
  logic        m_scl_low;
  logic        m_sda_low;
  logic [2:0]  hs_div;
  logic [6:0]  n1;
  logic [37:0] rfreq;
  logic        frozen;
  logic        new_freq;
  logic        bus_active;

  int          checks = 0;
  int          errors = 0;
  int          nf_pulses;
  logic        nf_clr;
  logic [63:0] exp_q[$];

  assign scl_bus = m_scl_low ? 1'b0 : 1'bz;
  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  si570_i2c_target #(.RecallCycles(RECALL_CYC)) dut (
    .clk(clk), .reset(reset), .scl(scl_bus), .sda(sda_bus),
    .hs_div(hs_div), .n1(n1), .rfreq(rfreq), .frozen(frozen),
    .new_freq(new_freq), .bus_active(bus_active)
  );

  // count clocks during which new_freq is high
  always @(negedge clk) begin
    if (nf_clr) nf_pulses <= 0;
    else if (new_freq === 1'b1) nf_pulses <= nf_pulses + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; wait_q();
    m_scl_low = 1'b0; wait_q();
    m_sda_low = 1'b1; wait_q();
    m_scl_low = 1'b1; wait_q();
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; wait_q();
    m_scl_low = 1'b0; wait_q();
    m_sda_low = 1'b0; wait_q();
  endtask

  task automatic send_bit(input logic b);
    m_sda_low = ~b; wait_q();
    m_scl_low = 1'b0; wait_q(); wait_q();
    m_scl_low = 1'b1; wait_q();
  endtask

  task automatic recv_bit(output logic b);
    m_sda_low = 1'b0; wait_q();
    m_scl_low = 1'b0; wait_q();
    b = sda_bus; wait_q();
    m_scl_low = 1'b1; wait_q();
  endtask

  // exp_ack = 1 means the target must pull SDA low in the 9th bit
  task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string tag);
    logic ack_bit;
    exp_q.push_back({63'd0, exp_ack});
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(ack_bit);
    check_eq(tag, {63'd0, ~ack_bit}, exp_q.pop_front());
  endtask

  task automatic read_byte(input logic [7:0] exp, input logic m_ack, input string tag);
    logic [7:0] got;
    logic       b;
    exp_q.push_back({56'd0, exp});
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      got[i] = b;
    end
    send_bit(~m_ack);
    check_eq(tag, {56'd0, got}, exp_q.pop_front());
  endtask

  task automatic write_reg(input logic [7:0] ptr, input logic [7:0] data);
    i2c_start();
    write_byte(8'hAA, 1'b1, "wr_addr_ack");
    write_byte(ptr, 1'b1, "wr_ptr_ack");
    write_byte(data, 1'b1, "wr_data_ack");
    i2c_stop();
  endtask

  task automatic set_ptr_for_read(input logic [7:0] ptr);
    i2c_start();
    write_byte(8'hAA, 1'b1, "rd_addr_w_ack");
    write_byte(ptr, 1'b1, "rd_ptr_ack");
    i2c_start();
    write_byte(8'hAB, 1'b1, "rd_addr_r_ack");
  endtask

  task automatic read_reg(input logic [7:0] ptr, input logic [7:0] exp, input string tag);
    set_ptr_for_read(ptr);
    read_byte(exp, 1'b0, tag);
    i2c_stop();
  endtask

  task automatic check_applied(input logic [2:0] h, input logic [6:0] n,
                               input logic [37:0] r, input string tag);
    check_eq({tag, "_hs_div"}, {61'd0, hs_div}, {61'd0, h});
    check_eq({tag, "_n1"}, {57'd0, n1}, {57'd0, n});
    check_eq({tag, "_rfreq"}, {26'd0, rfreq}, {26'd0, r});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    reset = 1'b1; m_scl_low = 1'b0; m_sda_low = 1'b0; nf_clr = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0; nf_clr = 1'b0;
    @(negedge clk);

    // reset state
    check_applied(3'd2, 7'd7, 38'h2BC0000000, "rst");
    check_eq("rst_frozen", {63'd0, frozen}, 64'd0);
    check_eq("rst_new_freq", {63'd0, new_freq}, 64'd0);
    check_eq("rst_bus_active", {63'd0, bus_active}, 64'd0);
    check_eq("rst_sda", {63'd0, sda_bus}, 64'd1);
    check_eq("rst_scl", {63'd0, scl_bus}, 64'd1);

    // freeze, load new dividers, unfreeze
    i2c_start();
    check_eq("bus_active_after_start", {63'd0, bus_active}, 64'd1);
    write_byte(8'hAA, 1'b1, "frz_addr_ack");
    write_byte(8'd137, 1'b1, "frz_ptr_ack");
    write_byte(8'h10, 1'b1, "frz_data_ack");
    i2c_stop();
    check_eq("bus_active_after_stop", {63'd0, bus_active}, 64'd0);
    check_eq("frozen_set", {63'd0, frozen}, 64'd1);
    i2c_start();
    write_byte(8'hAA, 1'b1, "cfg_addr_ack");
    write_byte(8'd7, 1'b1, "cfg_ptr_ack");
    write_byte(8'h22, 1'b1, "cfg_r7_ack");
    write_byte(8'h42, 1'b1, "cfg_r8_ack");
    write_byte(8'hF0, 1'b1, "cfg_r9_ack");
    write_byte(8'h00, 1'b1, "cfg_r10_ack");
    write_byte(8'h00, 1'b1, "cfg_r11_ack");
    write_byte(8'h00, 1'b1, "cfg_r12_ack");
    i2c_stop();
    check_applied(3'd2, 7'd7, 38'h2BC0000000, "while_frozen");
    write_reg(8'd137, 8'h00);
    check_eq("frozen_clr", {63'd0, frozen}, 64'd0);
    check_applied(3'd1, 7'd9, 38'h2F0000000, "thawed");

    // wrong address: no ACK anywhere, nothing changes
    i2c_start();
    write_byte(8'hA8, 1'b0, "bad_addr_nack");
    write_byte(8'd7, 1'b0, "bad_ptr_nack");
    write_byte(8'h55, 1'b0, "bad_data_nack");
    i2c_stop();
    check_applied(3'd1, 7'd9, 38'h2F0000000, "after_bad_addr");
    read_reg(8'd7, 8'h22, "reg7_after_bad_addr");

    // RECALL: reads 1 for a while, then 0; shadow back to factory
    write_reg(8'd135, 8'h01);
    read_reg(8'd135, 8'h01, "recall_busy");
    repeat (RECALL_CYC) @(negedge clk);
    read_reg(8'd135, 8'h00, "recall_done");
    set_ptr_for_read(8'd7);
    read_byte(8'h41, 1'b1, "factory_r7");
    read_byte(8'hEB, 1'b1, "factory_r8");
    read_byte(8'hC0, 1'b1, "factory_r9");
    read_byte(8'h00, 1'b1, "factory_r10");
    read_byte(8'h00, 1'b1, "factory_r11");
    read_byte(8'h00, 1'b0, "factory_r12");
    i2c_stop();
    check_applied(3'd1, 7'd9, 38'h2F0000000, "after_recall");

    // burst read from 12 running into unmapped registers, NACK ends it
    write_reg(8'd12, 8'h5A);
    set_ptr_for_read(8'd12);
    read_byte(8'h5A, 1'b1, "burst_r12");
    read_byte(8'h00, 1'b1, "burst_r13");
    read_byte(8'h00, 1'b0, "burst_r14");
    wait_q();
    check_eq("sda_released_after_nack", {63'd0, sda_bus}, 64'd1);
    i2c_stop();

    // NewFreq while not frozen: single pulse, applied = shadow
    nf_clr = 1'b1; @(negedge clk); nf_clr = 1'b0;
    write_reg(8'd135, 8'h40);
    check_eq("newfreq_pulse_len", nf_pulses, 64'd1);
    check_applied(3'd2, 7'd7, 38'h2BC000005A, "newfreq");

    // RECALL and NewFreq together: factory values applied
    write_reg(8'd7, 8'h22);
    nf_clr = 1'b1; @(negedge clk); nf_clr = 1'b0;
    write_reg(8'd135, 8'h41);
    check_eq("recall_newfreq_pulse_len", nf_pulses, 64'd1);
    check_applied(3'd2, 7'd7, 38'h2BC0000000, "recall_newfreq");

    // reset while the target is driving the address ACK
    i2c_start();
    b = 8'hAA;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_sda_low = 1'b0; wait_q();
    check_eq("ack_before_reset", {63'd0, sda_bus}, 64'd0);
    reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
    check_eq("sda_after_reset_ack", {63'd0, sda_bus}, 64'd1);
    i2c_stop();

    // reset during the 5th bit of a data byte to reg 9
    write_reg(8'd9, 8'h33);
    i2c_start();
    write_byte(8'hAA, 1'b1, "rst9_addr_ack");
    write_byte(8'd9, 1'b1, "rst9_ptr_ack");
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    m_sda_low = 1'b0; wait_q();
    m_scl_low = 1'b0; wait_q();
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    check_eq("sda_after_reset_data", {63'd0, sda_bus}, 64'd1);
    check_eq("bus_active_after_reset", {63'd0, bus_active}, 64'd0);
    wait_q();
    m_scl_low = 1'b1; wait_q();
    i2c_stop();
    check_applied(3'd2, 7'd7, 38'h2BC0000000, "after_reset");
    read_reg(8'd9, 8'hC0, "reg9_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
